// File: rtl/matmul_seq_2x2.sv
// matmul_seq_2x2
// Sequencer that computes C = A x B for signed 2x2 matrices on an external
// 2x2 MAC array. One job walks IDLE -> CLEAR -> K0 -> K1 -> SETTLE -> OUT.
// The accumulators are cleared first, then fed two rank-1 updates (k = 0, 1).
// The settled accumulators are captured into c_mat, which is held in OUT
// until the downstream handshake completes.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   job request handshake; a_mat, b_mat sampled on accept
//   out_valid / out_ready result handshake; c_mat stays valid while out_valid
//   mac_en, mac_clear     accumulate enable and clear to the MAC array
//   mac_a, mac_b          per-cell MAC operands, zero when not accumulating
//   mac_acc               per-cell accumulator values from the MAC array
//   busy                  high whenever the sequencer is not idle
//   job_count             completed jobs, wraps at 16 bits
module matmul_seq_2x2 #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_mat   [2][2],
    input  logic signed [DATA_W-1:0] b_mat   [2][2],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  c_mat   [2][2],
    output logic                     mac_en,
    output logic                     mac_clear,
    output logic signed [DATA_W-1:0] mac_a   [2][2],
    output logic signed [DATA_W-1:0] mac_b   [2][2],
    input  logic signed [ACC_W-1:0]  mac_acc [2][2],
    output logic                     busy,
    output logic [15:0]              job_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_K0,
        S_K1,
        S_SETTLE,
        S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  a_q [2][2];
    logic signed [DATA_W-1:0]  a_d [2][2];
    logic signed [DATA_W-1:0]  b_q [2][2];
    logic signed [DATA_W-1:0]  b_d [2][2];
    logic signed [ACC_W-1:0]   c_q [2][2];
    logic signed [ACC_W-1:0]   c_d [2][2];
    logic [15:0]               job_count_q, job_count_d;
    // Low during reset and set at the first edge after release, so in_ready
    // stays low while rst_n is asserted even though the state is IDLE.
    logic                      live_q;
    logic                      accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        job_count_d = job_count_q;
        in_ready    = (state_q == S_IDLE) && live_q;
        out_valid   = 1'b0;
        mac_en      = 1'b0;
        mac_clear   = 1'b0;
        busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = a_mat;
                    b_d     = b_mat;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Always clear before accumulating: an aborted job may have
                // left partial sums in the array.
                mac_clear = 1'b1;
                state_d   = S_K0;
            end
            S_K0: begin
                mac_en  = 1'b1;
                state_d = S_K1;
            end
            S_K1: begin
                mac_en  = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // The K1 update landed at the edge that entered SETTLE, so
                // mac_acc is final here.
                c_d     = mac_acc;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    job_count_d = job_count_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            c_q         <= '{default: '0};
            job_count_q <= 16'd0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            job_count_q <= job_count_d;
            live_q      <= 1'b1;
        end
    end

    // Operand fan-out: cell (i,j) sees row i of A and column j of B for the
    // current k, giving the outer product A[:,k] x B[k,:].
    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_row
            for (gj = 0; gj < 2; gj++) begin : g_col
                assign mac_a[gi][gj] = (state_q == S_K0) ? a_q[gi][0] :
                                       (state_q == S_K1) ? a_q[gi][1] : '0;
                assign mac_b[gi][gj] = (state_q == S_K0) ? b_q[0][gj] :
                                       (state_q == S_K1) ? b_q[1][gj] : '0;
                assign c_mat[gi][gj] = c_q[gi][gj];
            end
        end
    endgenerate

    assign job_count = job_count_q;

endmodule

// File: tb/tb_matmul_seq_2x2.sv
module tb_matmul_seq_2x2;

    localparam int DW = 8;
    localparam int AW = 32;

    typedef logic [3:0][DW-1:0] mat_ab_t;   // element index = row*2 + col
    typedef logic [3:0][AW-1:0] mat_c_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] a_mat [2][2];
    logic signed [DW-1:0] b_mat [2][2];
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [AW-1:0] c_mat [2][2];
    logic                 mac_en;
    logic                 mac_clear;
    logic signed [DW-1:0] mac_a [2][2];
    logic signed [DW-1:0] mac_b [2][2];
    logic signed [AW-1:0] acc [2][2];
    logic                 busy;
    logic [15:0]          job_count;

    int     checks = 0;
    int     errors = 0;
    int     exp_jobs = 0;
    mat_c_t exp_q[$];

    always #5 clk = ~clk;

    matmul_seq_2x2 #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mat     (a_mat),
        .b_mat     (b_mat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_mat     (c_mat),
        .mac_en    (mac_en),
        .mac_clear (mac_clear),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (acc),
        .busy      (busy),
        .job_count (job_count)
    );

    // Behavioural MAC array: not reset, so stale sums survive an aborted job.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (mac_clear)   acc[i][j] <= '0;
                else if (mac_en) acc[i][j] <= acc[i][j] + mac_a[i][j] * mac_b[i][j];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mat_ab_t mk(input int m00, input int m01, input int m10, input int m11);
        mat_ab_t r;
        r[0] = DW'(m00); r[1] = DW'(m01); r[2] = DW'(m10); r[3] = DW'(m11);
        return r;
    endfunction

    function automatic mat_c_t ref_mul(input mat_ab_t a, input mat_ab_t b);
        mat_c_t r;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'($signed(a[i*2+k])) * int'($signed(b[k*2+j]));
                r[i*2+j] = AW'(s);
            end
        return r;
    endfunction

    task automatic drive_ab(input mat_ab_t a, input mat_ab_t b);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                a_mat[i][j] = a[i*2+j];
                b_mat[i][j] = b[i*2+j];
            end
    endtask

    task automatic check_ops(input string tag, input mat_ab_t ea, input mat_ab_t eb);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("%s_mac_a%0d%0d", tag, i, j), {24'b0, mac_a[i][j]}, {24'b0, ea[i*2+j]});
                chk($sformatf("%s_mac_b%0d%0d", tag, i, j), {24'b0, mac_b[i][j]}, {24'b0, eb[i*2+j]});
            end
    endtask

    task automatic check_c(input string tag, input mat_c_t e);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                chk($sformatf("%s_c%0d%0d", tag, i, j), c_mat[i][j], e[i*2+j]);
    endtask

    // Runs one job from an IDLE negedge to the IDLE negedge after the output
    // handshake. After the accept edge the inputs switch to a_nxt/b_nxt/v_nxt.
    task automatic run_job(input mat_ab_t a, input mat_ab_t b, input int stall,
                           input mat_ab_t a_nxt, input mat_ab_t b_nxt, input logic v_nxt);
        mat_ab_t zero = '0;
        mat_ab_t ka, kb;
        mat_c_t  e;
        drive_ab(a, b);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        exp_q.push_back(ref_mul(a, b));
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);                                         // CLEAR
        drive_ab(a_nxt, b_nxt);
        in_valid = v_nxt;
        chk("clr_mac_clear", {31'b0, mac_clear}, 32'd1);
        chk("clr_mac_en",    {31'b0, mac_en},    32'd0);
        chk("clr_busy",      {31'b0, busy},      32'd1);
        chk("clr_in_ready",  {31'b0, in_ready},  32'd0);
        check_ops("clr", zero, zero);
        @(negedge clk);                                         // K0
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ka[i*2+j] = a[i*2+0];
                kb[i*2+j] = b[0*2+j];
            end
        chk("k0_mac_en",    {31'b0, mac_en},    32'd1);
        chk("k0_mac_clear", {31'b0, mac_clear}, 32'd0);
        check_ops("k0", ka, kb);
        @(negedge clk);                                         // K1
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ka[i*2+j] = a[i*2+1];
                kb[i*2+j] = b[1*2+j];
            end
        chk("k1_mac_en",    {31'b0, mac_en},    32'd1);
        chk("k1_mac_clear", {31'b0, mac_clear}, 32'd0);
        check_ops("k1", ka, kb);
        @(negedge clk);                                         // SETTLE
        chk("st_mac_en",    {31'b0, mac_en},    32'd0);
        chk("st_mac_clear", {31'b0, mac_clear}, 32'd0);
        chk("st_out_valid", {31'b0, out_valid}, 32'd0);
        check_ops("st", zero, zero);
        @(negedge clk);                                         // OUT, accept edge counted as first
        for (int s = 0; s < stall; s++) begin
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
            chk("stall_job_count", {16'b0, job_count}, 32'(exp_jobs));
            check_c("stall", exp_q[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("out_valid",    {31'b0, out_valid}, 32'd1);
        chk("out_in_ready", {31'b0, in_ready},  32'd0);
        chk("out_mac_en",   {31'b0, mac_en},    32'd0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check_c("out", e);
        @(negedge clk);                                         // IDLE
        exp_jobs++;
        chk("done_out_valid", {31'b0, out_valid}, 32'd0);
        chk("done_busy",      {31'b0, busy},      32'd0);
        chk("done_job_count", {16'b0, job_count}, 32'(exp_jobs));
        check_c("hold", e);
        $display("job %0d done stall=%0d c=[[%0d,%0d],[%0d,%0d]]", exp_jobs, stall,
                 $signed(e[0]), $signed(e[1]), $signed(e[2]), $signed(e[3]));
    endtask

    task automatic check_idle_outputs(input string tag);
        mat_ab_t zero = '0;
        chk({tag, "_in_ready"},  {31'b0, in_ready},  32'd0);
        chk({tag, "_busy"},      {31'b0, busy},      32'd0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_mac_en"},    {31'b0, mac_en},    32'd0);
        chk({tag, "_mac_clear"}, {31'b0, mac_clear}, 32'd0);
        chk({tag, "_job_count"}, {16'b0, job_count}, 32'd0);
        check_c(tag, '0);
        check_ops(tag, zero, zero);
    endtask

    initial begin
        mat_ab_t z  = '0;
        mat_ab_t g1 = mk(99, -7, 55, 13);
        mat_ab_t ra, rb;
        drive_ab(z, z);

        // Power-on reset
        @(negedge clk);
        check_idle_outputs("rst");
        #1 rst_n = 1'b1;
        chk("rel_in_ready_pre", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Reference product; inputs scrambled right after accept
        run_job(mk(1, 2, 3, 4), mk(5, 6, 7, 8), 0, g1, g1, 1'b0);
        // Most negative operands and sign handling
        run_job(mk(-128, -128, -128, -128), mk(-128, -128, -128, -128), 0, z, z, 1'b0);
        run_job(mk(-1, 0, 0, -1), mk(3, -4, 5, 6), 0, z, z, 1'b0);
        // Long stall in OUT with in_valid held high, then back-to-back pair
        run_job(mk(7, -3, 2, 9), mk(-5, 4, 11, -2), 10, mk(10, 20, 30, 40), mk(-1, 1, -1, 1), 1'b1);
        run_job(mk(10, 20, 30, 40), mk(-1, 1, -1, 1), 0, mk(-9, 8, 7, -6), mk(5, 5, -5, 5), 1'b1);
        run_job(mk(-9, 8, 7, -6), mk(5, 5, -5, 5), 0, z, z, 1'b0);

        // Reset during K1 aborts the job
        drive_ab(mk(2, -3, 4, 5), mk(1, 1, 1, 1));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_k1_mac_en", {31'b0, mac_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        exp_jobs = 0;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        run_job(mk(3, 1, -2, 4), mk(6, -1, 2, 7), 0, z, z, 1'b0);

        // A few random jobs
        for (int n = 0; n < 3; n++) begin
            for (int e = 0; e < 4; e++) begin
                ra[e] = DW'($urandom_range(255));
                rb[e] = DW'($urandom_range(255));
            end
            run_job(ra, rb, int'($urandom_range(3)), z, z, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
